// File: rtl/spi_slave_rx.sv
// SPI receive stage: oversampled sclk/cs/mosi in, LSB-first words out on a valid/ready port in clk domain.
// Latency: last sclk fall to dout_valid is SYNC_STAGES+1 clk cycles.
// Backpressure: a word completing while the previous one is still held is dropped and flags overrun.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr
);

    localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_q;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    // Only the upper DATA_W-1 bits of the shift register are kept: bit 0 would be
    // shifted out on the very edge that completes the word, so it is never needed.
    logic [DATA_W-2:0]      r_shreg;
    logic                   r_busy;
    logic [DATA_W-1:0]      r_dout;
    logic                   r_dout_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_cs_s;
    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_fall;
    logic                   w_word_done;
    logic [DATA_W-1:0]      w_new_word;
    logic                   w_frame_err_set;
    logic                   w_overrun_set;

    // Synchronise the asynchronous SPI pins; cs idles high, sclk/mosi idle low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_q    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_q    <= w_sclk_s;
        end
    end

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_fall   = r_sclk_q & ~w_sclk_s;

    // A raised cs always wins over a simultaneous sclk fall, so every event below is gated by !w_cs_s.
    assign w_word_done     = (r_state == S_RECV) && !w_cs_s && w_fall && (r_bit_cnt == LAST);
    assign w_new_word      = {w_mosi_s, r_shreg};
    assign w_frame_err_set = ((r_state == S_RECV) && w_cs_s && (r_bit_cnt != '0)) ||
                             ((r_state == S_DONE) && !w_cs_s && w_fall);
    assign w_overrun_set   = w_word_done && r_dout_valid && !dout_ready;

    // Frame FSM: tracks cs window, counts sclk falls and shifts data in LSB first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_cs_s) begin
                        r_state   <= S_RECV;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                    end
                end
                S_RECV: begin
                    if (w_cs_s) begin
                        // Partial words are simply abandoned; the error flag is raised elsewhere.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_fall) begin
                        r_shreg <= {w_mosi_s, r_shreg[DATA_W-2:1]};
                        if (r_bit_cnt == LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_cs_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: load on completion unless an unconsumed word would be overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_word_done && (!r_dout_valid || dout_ready)) begin
            r_dout       <= w_new_word;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the err_clr cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_set | (r_frame_err & ~err_clr);
            r_overrun   <= w_overrun_set   | (r_overrun   & ~err_clr);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of whole frames plus hand-written corner sequences.
// Master model drives sclk at clk/8, mosi changes on rise, LSB first.
// Accepted words are captured by a monitor into a queue and compared to expected values.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] acc_q[$];

    spi_slave_rx #(.DATA_W(12), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Record every handshake that will complete at the next rising edge.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) acc_q.push_back(dout);
    end

    typedef struct {
        logic [11:0] word;
        logic        rdy;
        logic [11:0] exp_dout;
        logic        exp_vld;
        logic        exp_ovr;
        int          exp_acc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drop cs and clock out n bits; returns just after the final sclk fall is driven.
    task automatic send_bits(input logic [15:0] w, input int n);
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            mosi = w[i];
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            if (i != n - 1) tick(4);
        end
    endtask

    task automatic finish_frame();
        tick(4);
        cs = 1'b1;
        tick(6);
    endtask

    function automatic logic [11:0] q_at(input int idx);
        if (acc_q.size() > idx) return acc_q[idx];
        return 12'hxxx;
    endfunction

    initial begin
        vecs[0] = '{12'hA5C, 1'b1, 12'hA5C, 1'b0, 1'b0, 1};
        vecs[1] = '{12'h001, 1'b1, 12'h001, 1'b0, 1'b0, 1};
        vecs[2] = '{12'hFFF, 1'b1, 12'hFFF, 1'b0, 1'b0, 1};
        vecs[3] = '{12'h0F0, 1'b1, 12'h0F0, 1'b0, 1'b0, 1};
        vecs[4] = '{12'h123, 1'b0, 12'h123, 1'b1, 1'b0, 0};
        vecs[5] = '{12'hFED, 1'b0, 12'h123, 1'b1, 1'b1, 0};

        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        dout_ready = 1'b0; err_clr = 1'b0;
        tick(3);
        check("reset dout",      32'(dout),       32'h0);
        check("reset valid",     32'(dout_valid), 32'h0);
        check("reset busy",      32'(busy),       32'h0);
        check("reset frame_err", 32'(frame_err),  32'h0);
        check("reset overrun",   32'(overrun),    32'h0);
        rst = 1'b1;
        tick(3);

        // cs window with no sclk activity: busy while low, no error on release.
        cs = 1'b0;
        tick(8);
        check("empty window busy", 32'(busy), 32'h1);
        cs = 1'b1;
        tick(6);
        check("empty window idle", 32'(busy), 32'h0);
        check("empty window ferr", 32'(frame_err), 32'h0);

        // Latency: valid must rise exactly three clocks after the final fall.
        dout_ready = 1'b1;
        acc_q.delete();
        send_bits(16'h0A5C, 12);
        tick(2);
        check("latency early", 32'(dout_valid), 32'h0);
        tick(1);
        check("latency valid", 32'(dout_valid), 32'h1);
        check("latency dout",  32'(dout),       32'hA5C);
        finish_frame();
        check("latency one accept", 32'(acc_q.size()), 32'd1);

        for (int k = 0; k < 6; k++) begin
            dout_ready = vecs[k].rdy;
            acc_q.delete();
            send_bits({4'h0, vecs[k].word}, 12);
            finish_frame();
            tick(2);
            check($sformatf("vec%0d accepts", k), 32'(acc_q.size()), 32'(vecs[k].exp_acc));
            if (vecs[k].exp_acc > 0)
                check($sformatf("vec%0d word", k), 32'(q_at(0)), 32'(vecs[k].exp_dout));
            check($sformatf("vec%0d dout", k),    32'(dout),       32'(vecs[k].exp_dout));
            check($sformatf("vec%0d valid", k),   32'(dout_valid), 32'(vecs[k].exp_vld));
            check($sformatf("vec%0d overrun", k), 32'(overrun),    32'(vecs[k].exp_ovr));
            check($sformatf("vec%0d ferr", k),    32'(frame_err),  32'h0);
            check($sformatf("vec%0d busy", k),    32'(busy),       32'h0);
        end

        // Clear overrun while the old word is still held, then drain it.
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        check("errclr overrun", 32'(overrun),    32'h0);
        check("errclr held",    32'(dout_valid), 32'h1);
        acc_q.delete();
        dout_ready = 1'b1;
        tick(2);
        check("drain word",  32'(q_at(0)),      32'h123);
        check("drain valid", 32'(dout_valid),   32'h0);

        // Completion in the same cycle the held word is consumed: replace, valid stays high.
        dout_ready = 1'b0;
        send_bits(16'h03C3, 12);
        finish_frame();
        acc_q.delete();
        send_bits(16'h00A5, 12);
        tick(2);
        dout_ready = 1'b1;
        tick(1);
        check("swap dout",    32'(dout),       32'h0A5);
        check("swap valid",   32'(dout_valid), 32'h1);
        check("swap overrun", 32'(overrun),    32'h0);
        tick(1);
        check("swap count",  32'(acc_q.size()), 32'd2);
        check("swap first",  32'(q_at(0)),      32'h3C3);
        check("swap second", 32'(q_at(1)),      32'h0A5);
        finish_frame();

        // cs rises after 5 bits: partial word discarded, frame error raised.
        acc_q.delete();
        send_bits(16'h001F, 5);
        check("abort busy", 32'(busy), 32'h1);
        finish_frame();
        check("abort ferr",    32'(frame_err),    32'h1);
        check("abort idle",    32'(busy),         32'h0);
        check("abort nodata",  32'(acc_q.size()), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        check("abort cleared", 32'(frame_err), 32'h0);
        send_bits(16'h00F0, 12);
        finish_frame();
        check("after abort word", 32'(q_at(0)),   32'h0F0);
        check("after abort ferr", 32'(frame_err), 32'h0);

        // Thirteen falls in one window: word delivered, extra fall flagged.
        acc_q.delete();
        send_bits(16'h0800, 13);
        finish_frame();
        check("extra count", 32'(acc_q.size()), 32'd1);
        check("extra word",  32'(q_at(0)),      32'h800);
        check("extra ferr",  32'(frame_err),    32'h1);
        check("extra ovr",   32'(overrun),      32'h0);

        // Asynchronous reset mid-frame clears everything without waiting for a clock.
        send_bits(16'h0555, 6);
        check("midreset busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("midreset dout",  32'(dout),       32'h0);
        check("midreset valid", 32'(dout_valid), 32'h0);
        check("midreset busy0", 32'(busy),       32'h0);
        check("midreset ferr",  32'(frame_err),  32'h0);
        check("midreset ovr",   32'(overrun),    32'h0);
        cs = 1'b1;
        sclk = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(4);
        acc_q.delete();
        send_bits(16'h0AAA, 12);
        finish_frame();
        check("post reset count", 32'(acc_q.size()), 32'd1);
        check("post reset word",  32'(q_at(0)),      32'hAAA);
        check("post reset ferr",  32'(frame_err),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
